logicfunction_response_checker: RTL

Receiving end of the 4-input logic-function test interface. Samples each applied input vector together with the DUT output f, and compares f against a parameterised 16-entry truth table. Tracks which of the 16 vectors have been covered, counts mismatches, and latches the first failing vector. Reports done/pass once all 16 vectors are covered, or reports a timeout if the stimulus stalls.

---
 rtl/logicfunction_pkg.sv | 14 +
 rtl/lfc_timeout_counter.sv | 36 +++
 rtl/logicfunction_response_checker.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/logicfunction_pkg.sv
// rtl/logicfunction_pkg.sv - shared encodings and constants for the logic-function response checker
package logicfunction_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } lfc_state_t;

    localparam int               NUM_VECTORS = 16;
    localparam logic [15:0]      ALL_COVERED = 16'hFFFF;
    localparam logic [4:0]       ERR_SAT     = 5'd31;

endpackage

// File: rtl/lfc_timeout_counter.sv
// rtl/lfc_timeout_counter.sv - stall counter; expired flags the edge on which the count reaches TIMEOUT
module lfc_timeout_counter #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CW'(1);
        end
    end

    // Look-ahead so the owner can leave RUN on the very edge the count hits TIMEOUT.
    assign expired = enable && !clear && (count_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/logicfunction_response_checker.sv
// rtl/logicfunction_response_checker.sv - checks sampled f against a 16-entry truth table, tracks coverage and errors
module logicfunction_response_checker
    import logicfunction_pkg::*;
#(
    parameter logic [15:0] TRUTH_TABLE = 16'h6996,
    parameter int          TIMEOUT     = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   vec_valid,
    input  logic [3:0]             vec,
    input  logic                   f,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic                   timeout,
    output logic [4:0]             err_count,
    output logic                   first_fail_valid,
    output logic [3:0]             first_fail_vec,
    output logic [NUM_VECTORS-1:0] coverage
);

    lfc_state_t state_q, state_d;

    logic                   busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic                   timeout_q, timeout_d, ffv_q, ffv_d;
    logic [4:0]             err_q, err_d;
    logic [3:0]             ffvec_q, ffvec_d;
    logic [NUM_VECTORS-1:0] cov_q, cov_d;

    logic                   sample, mismatch, expired;
    logic [NUM_VECTORS-1:0] cov_upd;
    logic [4:0]             err_upd;

    // start wins over a coincident sample, which is then dropped
    assign sample   = (state_q == RUN) && vec_valid && !start;
    assign mismatch = (f != TRUTH_TABLE[vec]);
    assign cov_upd  = cov_q | (NUM_VECTORS'(1) << vec);
    assign err_upd  = (mismatch && err_q != ERR_SAT) ? err_q + 5'd1 : err_q;

    lfc_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (start || vec_valid || state_q != RUN),
        .enable  (state_q == RUN),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = RUN;
        end else if (state_q == RUN) begin
            if (sample && cov_upd == ALL_COVERED) begin
                state_d = DONE;
            end else if (expired) begin
                state_d = DONE;
            end
        end
    end

    always_comb begin
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        err_d     = err_q;
        ffv_d     = ffv_q;
        ffvec_d   = ffvec_q;
        cov_d     = cov_q;
        if (start) begin
            busy_d    = 1'b1;
            done_d    = 1'b0;
            pass_d    = 1'b0;
            timeout_d = 1'b0;
            err_d     = '0;
            ffv_d     = 1'b0;
            ffvec_d   = '0;
            cov_d     = '0;
        end else if (state_q == RUN) begin
            if (sample) begin
                cov_d = cov_upd;
                err_d = err_upd;
                if (mismatch && !ffv_q) begin
                    ffv_d   = 1'b1;
                    ffvec_d = vec;
                end
                if (cov_upd == ALL_COVERED) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    pass_d = (err_upd == '0);
                end
            end else if (expired) begin
                busy_d    = 1'b0;
                done_d    = 1'b1;
                pass_d    = 1'b0;
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= '0;
            ffv_q     <= 1'b0;
            ffvec_q   <= '0;
            cov_q     <= '0;
        end else begin
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
            ffv_q     <= ffv_d;
            ffvec_q   <= ffvec_d;
            cov_q     <= cov_d;
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign timeout          = timeout_q;
    assign err_count        = err_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_vec   = ffvec_q;
    assign coverage         = cov_q;

endmodule
